// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch controller: FSM encoding and BCD digit helpers.
package stopwatch_pkg;

  localparam int BCD_W = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  // Next value of a single decimal digit; 9 rolls over to 0.
  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] d);
    return (d == BCD_MAX) ? '0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Raw active-low key -> 2-flop synchroniser -> stability debouncer -> one-cycle press strobe.
module key_debounce #(
  parameter int DEBOUNCE_CYC = 240000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= key_raw;
      sync_q2 <= sync_q1;
    end
  end

  // cnt counts consecutive samples that disagree with the accepted level;
  // any agreeing sample restarts the count, so bounces never get through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b1;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync_q2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync_q2;
        press <= ~sync_q2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: debounced run/lap/clear keys, IDLE/RUN/PAUSE FSM,
// tick prescaler and a DIGITS-wide BCD counter with an optional lap freeze.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DIGITS       = 2,
  parameter int TICK_DIV     = 12000000,
  parameter int DEBOUNCE_CYC = 240000,
  parameter int WRAP         = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    key_run,
  input  logic                    key_lap,
  input  logic                    key_clr,
  output logic [BCD_W*DIGITS-1:0] bcd_out,
  output logic                    running,
  output logic                    lap_hold,
  output logic                    wrap_pulse,
  output logic [1:0]              state_dbg
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic                    run_p;
  logic                    lap_p;
  logic                    clr_p;
  logic [1:0]              state;
  logic [1:0]              state_next;
  logic [PW-1:0]           presc;
  logic                    tick;
  logic [DIGITS:0]         carry;
  logic [BCD_W*DIGITS-1:0] count;
  logic                    saturate;
  logic                    clr_all;

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_run (
    .clk(clk), .rst_n(rst_n), .key_raw(key_run), .press(run_p)
  );
  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_lap (
    .clk(clk), .rst_n(rst_n), .key_raw(key_lap), .press(lap_p)
  );
  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_clr (
    .clk(clk), .rst_n(rst_n), .key_raw(key_clr), .press(clr_p)
  );

  assign tick     = (state == ST_RUN) && (presc == PRESC_LAST);
  assign carry[0] = tick;
  // carry out of the top digit means the count was all-9s on this tick
  assign saturate = (WRAP == 0) && carry[DIGITS];

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (run_p) state_next = ST_RUN;
      ST_RUN:   if (run_p || saturate) state_next = ST_PAUSE;
      ST_PAUSE: begin
        if (clr_p)      state_next = ST_IDLE;
        else if (run_p) state_next = ST_RUN;
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  assign clr_all = (state_next == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               presc <= '0;
    else if (clr_all)         presc <= '0;
    else if (state == ST_RUN) presc <= tick ? '0 : presc + PW'(1);
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [BCD_W-1:0] digit_q;

    assign carry[i+1]                  = carry[i] && (digit_q == BCD_MAX);
    assign count[i*BCD_W +: BCD_W]     = digit_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                    digit_q <= '0;
      else if (clr_all)              digit_q <= '0;
      else if (carry[i] && !saturate) digit_q <= bcd_inc(digit_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wrap_pulse <= 1'b0;
    else        wrap_pulse <= carry[DIGITS];
  end

  // Lap toggles only while running; in PAUSE it can only release the freeze.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          lap_hold <= 1'b0;
    else if (clr_all)                    lap_hold <= 1'b0;
    else if (lap_p && state == ST_RUN)   lap_hold <= ~lap_hold;
    else if (lap_p && state == ST_PAUSE) lap_hold <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         bcd_out <= '0;
    else if (clr_all)   bcd_out <= '0;
    else if (!lap_hold) bcd_out <= count;
  end

  assign running   = (state == ST_RUN);
  assign state_dbg = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed key sequences, scoreboard of expected display changes.
module tb_stopwatch_ctrl;

  localparam int W       = 8;
  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rst_n_s = 1'b0;
  logic         key_run = 1'b1;
  logic         key_lap = 1'b1;
  logic         key_clr = 1'b1;
  logic [W-1:0] bcd_out, bcd_out_s;
  logic         running, lap_hold, wrap_pulse;
  logic         running_s, lap_hold_s, wrap_pulse_s;
  logic [1:0]   state_dbg, state_dbg_s;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int wrap_cnt = 0;
  int wrap_cnt_s = 0;
  int run_rise_cnt = 0;
  int run_rise_cyc = 0;
  int chg_cyc = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] prev_bcd = '0;
  logic         prev_running = 1'b0;

  stopwatch_ctrl #(.DIGITS(2), .TICK_DIV(10), .DEBOUNCE_CYC(4), .WRAP(1)) dut (
    .clk(clk), .rst_n(rst_n), .key_run(key_run), .key_lap(key_lap), .key_clr(key_clr),
    .bcd_out(bcd_out), .running(running), .lap_hold(lap_hold),
    .wrap_pulse(wrap_pulse), .state_dbg(state_dbg)
  );

  stopwatch_ctrl #(.DIGITS(2), .TICK_DIV(10), .DEBOUNCE_CYC(4), .WRAP(0)) dut_sat (
    .clk(clk), .rst_n(rst_n_s), .key_run(key_run), .key_lap(key_lap), .key_clr(key_clr),
    .bcd_out(bcd_out_s), .running(running_s), .lap_hold(lap_hold_s),
    .wrap_pulse(wrap_pulse_s), .state_dbg(state_dbg_s)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  function automatic logic [W-1:0] bcd2(input int v);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  task automatic push_range(input int lo, input int hi);
    for (int v = lo; v <= hi; v++) exp_q.push_back(bcd2(v));
  endtask

  // driver tasks
  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_key(input int k, input logic v);
    case (k)
      0:       key_run = v;
      1:       key_lap = v;
      default: key_clr = v;
    endcase
  endtask

  task automatic press_key(input int k);
    set_key(k, 1'b0);
    tick_n(10);
    set_key(k, 1'b1);
    tick_n(8);
  endtask

  task automatic wait_bcd(input logic [W-1:0] v, input int limit, input string name);
    int n;
    n = 0;
    while (bcd_out !== v && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, bcd_out, v);
  endtask

  // monitor / scoreboard: every change of the main display must match the next expected value
  initial begin
    forever begin
      @(negedge clk);
      if (wrap_pulse) wrap_cnt++;
      if (wrap_pulse_s) wrap_cnt_s++;
      if (running && !prev_running) begin
        run_rise_cnt++;
        run_rise_cyc = cyc;
      end
      prev_running = running;
      if (bcd_out !== prev_bcd) begin
        chg_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL bcd_seq: got change to %0h, required no change (queue empty)", bcd_out);
        end else begin
          check("bcd_seq", bcd_out, exp_q.pop_front());
        end
        prev_bcd = bcd_out;
      end
    end
  end

  initial begin
    int n;
    int c0;

    tick_n(3);
    check("rst_bcd", bcd_out, 0);
    check("rst_running", running, 0);
    check("rst_lap_hold", lap_hold, 0);
    check("rst_wrap", wrap_pulse, 0);
    check("rst_state", state_dbg, S_IDLE);
    check("rst_sat_bcd", bcd_out_s, 0);

    rst_n = 1'b1;
    tick_n(12);
    check("post_rst_no_press", running, 0);
    check("post_rst_state", state_dbg, S_IDLE);

    // bouncing run key, then a full lap of 100 ticks
    push_range(1, 99);
    exp_q.push_back(8'h00);
    key_run = 1'b0; tick_n(2);
    key_run = 1'b1; tick_n(2);
    key_run = 1'b0; tick_n(12);
    key_run = 1'b1; tick_n(8);
    check("bounce_one_press", run_rise_cnt, 1);
    check("bounce_running", running, 1);
    check("bounce_state", state_dbg, S_RUN);

    n = 0;
    while (wrap_cnt == 0 && n < 1200) begin
      @(negedge clk);
      n++;
    end
    tick_n(3);
    check("wrap_pulse_once", wrap_cnt, 1);
    check("wrap_running", running, 1);
    check("wrap_bcd", bcd_out, 8'h00);

    // lap freeze at 0x37, release at 0x42
    push_range(1, 37);
    wait_bcd(8'h37, 450, "reach_37");
    c0 = cyc;
    press_key(1);
    check("lap_hold_set", lap_hold, 1);
    check("lap_frozen_early", bcd_out, 8'h37);
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h43);
    while (cyc < c0 + 47) @(negedge clk);
    check("lap_frozen_late", bcd_out, 8'h37);
    key_lap = 1'b0;
    tick_n(8);
    check("lap_release_bcd", bcd_out, 8'h42);
    check("lap_release_flag", lap_hold, 0);
    tick_n(2);
    key_lap = 1'b1;
    tick_n(8);

    // pause with prescaler at 6, then resume
    exp_q.push_back(8'h44);
    exp_q.push_back(8'h45);
    wait_bcd(8'h44, 30, "reach_44");
    tick_n(8);
    press_key(0);
    check("pause_running", running, 0);
    check("pause_state", state_dbg, S_PAUSE);
    check("pause_bcd", bcd_out, 8'h45);
    exp_q.push_back(8'h46);
    press_key(0);
    check("resume_latency", chg_cyc - run_rise_cyc, 5);
    check("resume_bcd", bcd_out, 8'h46);
    check("resume_running", running, 1);

    // clear alone while running is ignored
    exp_q.push_back(8'h47);
    exp_q.push_back(8'h48);
    wait_bcd(8'h48, 30, "reach_48");
    exp_q.push_back(8'h49);
    exp_q.push_back(8'h50);
    press_key(2);
    check("clr_in_run_running", running, 1);
    check("clr_in_run_state", state_dbg, S_RUN);
    press_key(0);
    check("pause2_state", state_dbg, S_PAUSE);
    check("pause2_bcd", bcd_out, 8'h50);

    // run and clear together in PAUSE: clear wins
    exp_q.push_back(8'h00);
    key_run = 1'b0;
    key_clr = 1'b0;
    tick_n(10);
    key_run = 1'b1;
    key_clr = 1'b1;
    tick_n(8);
    check("runclr_state", state_dbg, S_IDLE);
    check("runclr_running", running, 0);
    check("runclr_bcd", bcd_out, 8'h00);
    press_key(1);
    check("lap_in_idle", lap_hold, 0);
    check("lap_in_idle_state", state_dbg, S_IDLE);

    // saturating instance: async reset mid-count, then saturate at 99
    rst_n = 1'b0;
    tick_n(2);
    rst_n_s = 1'b1;
    tick_n(10);
    press_key(0);
    tick_n(200);
    check("sat_running_before_rst", running_s, 1);
    @(posedge clk);
    #2;
    rst_n_s = 1'b0;
    #1;
    check("async_rst_bcd", bcd_out_s, 0);
    check("async_rst_running", running_s, 0);
    check("async_rst_lap", lap_hold_s, 0);
    check("async_rst_wrap", wrap_pulse_s, 0);
    check("async_rst_state", state_dbg_s, S_IDLE);
    @(negedge clk);
    rst_n_s = 1'b1;
    tick_n(5);
    press_key(0);
    n = 0;
    while (wrap_cnt_s == 0 && n < 1300) begin
      @(negedge clk);
      n++;
    end
    tick_n(3);
    check("sat_bcd", bcd_out_s, 8'h99);
    check("sat_wrap_once", wrap_cnt_s, 1);
    check("sat_running", running_s, 0);
    check("sat_state", state_dbg_s, S_PAUSE);
    tick_n(30);
    check("sat_bcd_hold", bcd_out_s, 8'h99);
    check("sat_wrap_still_once", wrap_cnt_s, 1);

    check("exp_q_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 The block SHALL have parameter DIGITS, default 2, number of BCD digits (legal 1..8).
REQ-002 The block SHALL have parameter TICK_DIV, default 12000000, clk cycles per count tick (legal >= 2).
REQ-003 The block SHALL have parameter DEBOUNCE_CYC, default 240000, stable cycles required to accept a key level (legal >= 2).
REQ-004 The block SHALL have parameter WRAP, default 1: 1 = wrap at maximum, 0 = saturate and pause.
REQ-005 The block SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-007 The block SHALL have port key_run, input, 1, raw active-low run/pause toggle key.
REQ-008 The block SHALL have port key_lap, input, 1, raw active-low lap-hold toggle key.
REQ-009 The block SHALL have port key_clr, input, 1, raw active-low clear key.
REQ-010 The block SHALL have port bcd_out, output, 4*DIGITS, displayed value; digit 0 (ones) in bits [3:0].
REQ-011 The block SHALL have port running, output, 1, high in state RUN.
REQ-012 The block SHALL have port lap_hold, output, 1, high while display is frozen.
REQ-013 The block SHALL have port wrap_pulse, output, 1, one-cycle pulse when count passes all-9s.

Function
REQ-014 Each key SHALL pass a 2-flop synchroniser, then a debouncer that adopts a new level only after DEBOUNCE_CYC consecutive equal samples; a 1-cycle press pulse SHALL fire on each debounced 1->0 transition.
REQ-015 The FSM SHALL have states IDLE (count zero, stopped), RUN, PAUSE.
REQ-016 Transitions: IDLE+run -> RUN; RUN+run -> PAUSE; PAUSE+run -> RUN; PAUSE+clr -> IDLE; IDLE+clr -> IDLE; clr in RUN ignored.
REQ-017 Simultaneous run and clr pulses in PAUSE SHALL give IDLE (clr wins); in RUN SHALL give PAUSE.
REQ-018 The prescaler SHALL count 0..TICK_DIV-1 only in RUN, hold its value in PAUSE, clear to 0 on entering IDLE, and emit an internal tick when it wraps to 0.
REQ-019 On a tick, the DIGITS-digit BCD counter SHALL increment by 1 with decimal carry; every digit stays 0..9.
REQ-020 At all-9s with WRAP=1, a tick SHALL load all-0 and assert wrap_pulse for exactly that next cycle; FSM stays RUN.
REQ-021 At all-9s with WRAP=0, a tick SHALL leave the count at all-9s, assert wrap_pulse one cycle, and move the FSM to PAUSE.
REQ-022 bcd_out SHALL be registered and follow the counter with 1-cycle latency unless lap_hold is high.
REQ-023 A lap press in RUN SHALL toggle lap_hold; while high, bcd_out holds the value at the press and counting continues.
REQ-024 A lap press in PAUSE SHALL clear lap_hold (bcd_out shows live count); in IDLE it is ignored.
REQ-025 Entering IDLE SHALL clear counter, prescaler, lap_hold, and bcd_out to zero in the same transition cycle.

Reset
REQ-026 While rst_n low: state IDLE, counter 0, prescaler 0, bcd_out 0, running 0, lap_hold 0, wrap_pulse 0, debounced levels 1, synchroniser flops 1.
REQ-027 Reset asserted mid-operation SHALL abort at once; no press pulse SHALL fire on the first cycles after release while keys are idle high.

Structure
REQ-028 The FSM state encoding and the BCD digit width constant SHALL live in shared package stopwatch_pkg.
REQ-029 Debouncing SHALL be one sub-module key_debounce (sync + stability counter + press pulse), instantiated three times.
REQ-030 The BCD counter SHALL be built with a generate loop over DIGITS; no division or modulo operators.

Verification (TICK_DIV=10, DEBOUNCE_CYC=4, DIGITS=2)
REQ-031 Reset, press run, wait 100 ticks -> bcd_out 0x00 after 0x99, wrap_pulse high exactly one cycle, running=1.
REQ-032 key_run bounces 1-0-1-0 at 2-cycle spacing then held low -> exactly one press pulse; state IDLE->RUN once.
REQ-033 Run to 0x37, press lap, wait 5 ticks -> bcd_out stays 0x37; second lap press -> bcd_out 0x42 next cycle.
REQ-034 Pause at prescaler 6, resume -> next increment after exactly 4 further RUN cycles.
REQ-035 In PAUSE, press run and clr in the same cycle -> IDLE, bcd_out 0x00, running 0; clr alone in RUN -> no change.
REQ-036 WRAP=0, run to 0x99, one more tick -> bcd_out 0x99, wrap_pulse one cycle, state PAUSE; assert rst_n mid-count -> all outputs 0 asynchronously.
